// File: rtl/btn_event_decoder.sv
// Turns one debounced button level into one-cycle user events: press, click,
// long press, auto-repeat and release. All outputs come straight from registers.
module btn_event_decoder #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 25_000_000,
  parameter int CNT_W         = 27
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_state_i,
  output logic press_o,
  output logic click_o,
  output logic long_press_o,
  output logic rpt_o,
  output logic release_o,
  output logic step_o,
  output logic held_o
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    REPEAT   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             rel_q, rel_d;
  logic             step_q, step_d;
  logic             held_q, held_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    click_d = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      // A button held through reset must be seen low once before it counts.
      WAIT_LOW: begin
        if (!btn_state_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (btn_state_i) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      // A low sample beats a long press due on the same edge.
      PRESSED: begin
        if (!btn_state_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          click_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_state_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d = '0;
          rpt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
    endcase
    step_d = press_d | rpt_d;
    held_d = (state_d == PRESSED) || (state_d == REPEAT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      press_q <= 1'b0;
      click_q <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      rel_q   <= 1'b0;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      click_q <= click_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      rel_q   <= rel_d;
      step_q  <= step_d;
      held_q  <= held_d;
    end
  end

  assign press_o      = press_q;
  assign click_o      = click_q;
  assign long_press_o = long_q;
  assign rpt_o        = rpt_q;
  assign release_o    = rel_q;
  assign step_o       = step_q;
  assign held_o       = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed vector bench for btn_event_decoder with LONG=8, REPEAT=4.
module tb_btn_event_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic press, click, long_press, rpt, rel, step, held;

  always #5 clk = ~clk;

  btn_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .btn_state_i(btn),
    .press_o(press), .click_o(click), .long_press_o(long_press), .rpt_o(rpt),
    .release_o(rel), .step_o(step), .held_o(held)
  );

  // exp bit order: {press, click, long_press, rpt, release, step, held}
  typedef struct {
    logic       rst_n;
    logic       btn;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  localparam logic [6:0] Z   = 7'b0000000;
  localparam logic [6:0] PR  = 7'b1000011;
  localparam logic [6:0] HLD = 7'b0000001;
  localparam logic [6:0] CLK = 7'b0100100;
  localparam logic [6:0] REL = 7'b0000100;
  localparam logic [6:0] LNG = 7'b0010001;
  localparam logic [6:0] RPT = 7'b0001011;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic b, input logic [6:0] e,
                     input int n, input string t);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst_n = r; v.btn = b; v.exp = e; v.tag = t;
      vecs.push_back(v);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic r, input logic b, output logic [6:0] got);
    @(negedge clk);
    rst_n = r;
    btn   = b;
    @(posedge clk);
    #1;
    got = {press, click, long_press, rpt, rel, step, held};
  endtask

  task automatic check(input string t, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", t, act, req);
    end
  endtask

  initial begin
    logic [6:0] got;
    int steps, longs, clicks, rels;

    // reset state, then leave reset with the button up
    add(0, 0, Z, 2, "reset");
    add(1, 0, Z, 2, "idle");
    // short press: high E0..E2, low E3
    add(1, 1, PR, 1, "short_press");
    add(1, 1, HLD, 2, "short_hold");
    add(1, 0, CLK, 1, "short_click");
    add(1, 0, Z, 2, "short_idle");
    // long hold: high E0..E19, low E20
    add(1, 1, PR, 1, "long_press0");
    add(1, 1, HLD, 7, "long_hold");
    add(1, 1, LNG, 1, "long_E8");
    add(1, 1, HLD, 3, "long_hold2");
    add(1, 1, RPT, 1, "rpt_E12");
    add(1, 1, HLD, 3, "long_hold3");
    add(1, 1, RPT, 1, "rpt_E16");
    add(1, 1, HLD, 3, "long_hold4");
    add(1, 0, REL, 1, "long_release");
    add(1, 0, Z, 1, "long_idle");
    // low exactly at E8: click wins over long press
    add(1, 1, PR, 1, "bnd_press");
    add(1, 1, HLD, 7, "bnd_hold");
    add(1, 0, CLK, 1, "bnd_click_E8");
    add(1, 0, Z, 1, "bnd_idle");
    // low exactly at E12: release wins over first repeat
    add(1, 1, PR, 1, "rb_press");
    add(1, 1, HLD, 7, "rb_hold");
    add(1, 1, LNG, 1, "rb_long");
    add(1, 1, HLD, 3, "rb_hold2");
    add(1, 0, REL, 1, "rb_rel_E12");
    add(1, 0, Z, 1, "rb_idle");
    // reset in REPEAT at E14, button kept high through and after reset
    add(1, 1, PR, 1, "rst_press");
    add(1, 1, HLD, 7, "rst_hold");
    add(1, 1, LNG, 1, "rst_long");
    add(1, 1, HLD, 3, "rst_hold2");
    add(1, 1, RPT, 1, "rst_rpt");
    add(1, 1, HLD, 1, "rst_hold3");
    add(0, 1, Z, 1, "rst_E14");
    add(1, 1, Z, 3, "rst_waitlow");
    add(1, 0, Z, 1, "rst_seen_low");
    add(1, 1, PR, 1, "rst_repress");
    add(1, 0, CLK, 1, "rst_click");
    add(1, 0, Z, 1, "rst_idle");
    // back-to-back 1,0,1 then hold to a fresh long press
    add(1, 1, PR, 1, "b2b_press");
    add(1, 0, CLK, 1, "b2b_click");
    add(1, 1, PR, 1, "b2b_repress");
    add(1, 1, HLD, 7, "b2b_hold");
    add(1, 1, LNG, 1, "b2b_long");
    add(1, 0, REL, 1, "b2b_release");
    add(1, 0, Z, 1, "b2b_idle");

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].btn, got);
      n_cmp++;
      if (got !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d %s: got %b want %b", i, vecs[i].tag, got, vecs[i].exp);
      end
    end

    // Event totals over a 20-edge hold: one press plus two repeats step.
    steps = 0; longs = 0; clicks = 0; rels = 0;
    for (int e = 0; e <= 20; e++) begin
      apply(1'b1, (e < 20) ? 1'b1 : 1'b0, got);
      steps  += int'(got[1]);
      longs  += int'(got[4]);
      clicks += int'(got[5]);
      rels   += int'(got[2]);
    end
    check("hold_step_count", steps, 3);
    check("hold_long_count", longs, 1);
    check("hold_click_count", clicks, 0);
    check("hold_release_count", rels, 1);

    // held falls on the same cycle release asserts.
    apply(1'b1, 1'b1, got);
    check("held_after_press", int'(held), 1);
    apply(1'b1, 1'b0, got);
    check("held_with_release", int'({held, rel}), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Consumes the debounced level of one front-panel button and turns it into one-cycle user events: press, short click, long press, auto-repeat and release.
- Sits between each button debouncer and the alarm-clock control logic.
- Auto-repeat drives fast increment while hours or minutes are held in set mode.
- One instance per button.

Parameters:
- LONG_CYCLES, 100_000_000, hold time in clk cycles before long_press fires (1 s at 100 MHz); must be at least 2.
- REPEAT_CYCLES, 25_000_000, period in clk cycles of rpt pulses after long_press; must be at least 2.
- CNT_W, 27, hold-counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- btn_state  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- press  output  1  one-cycle pulse on press acceptance.
- click  output  1  one-cycle pulse on release before long_press.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- rpt  output  1  one-cycle pulse every REPEAT_CYCLES after long_press while still held.
- release  output  1  one-cycle pulse on any accepted release.
- step  output  1  press OR rpt, same cycle; single increment strobe.
- held  output  1  level, 1 while state is PRESSED or REPEAT.

Behaviour:
- All outputs are registered.
- Pulses last exactly one cycle and appear in the cycle after the sampling edge that causes them.
- States: WAIT_LOW, IDLE, PRESSED, REPEAT. One hold counter cnt of width CNT_W.
- Reset: rst_n sampled 0 at an edge forces state WAIT_LOW, cnt 0, all outputs 0. Reset overrides everything, including mid-press.
- WAIT_LOW:
  - btn_state=0 -> IDLE.
  - btn_state=1 -> stay; no events.
  - A button held through reset produces nothing until it is seen low once.
- IDLE:
  - btn_state=1 at edge E0 -> PRESSED, cnt<=0, press=1 and step=1 after E0.
- PRESSED, at each edge:
  - btn_state=0 -> IDLE, release=1, click=1.
  - else if cnt==LONG_CYCLES-1 -> REPEAT, cnt<=0, long_press=1.
  - else cnt<=cnt+1.
  - Result: long_press follows E_L with L=LONG_CYCLES, provided btn_state was 1 at E1..E_L.
- REPEAT, at each edge:
  - btn_state=0 -> IDLE, release=1, click=0.
  - else if cnt==REPEAT_CYCLES-1 -> cnt<=0, rpt=1, step=1.
  - else cnt<=cnt+1.
  - Result: rpt follows E_(L+k*REPEAT_CYCLES) for k>=1.
- Priority and simultaneity:
  - A low sample always wins over a long_press or rpt due on the same edge; release is reported and the other event is dropped.
  - long_press and the first rpt never coincide.
  - press and release never coincide; the minimum press gives press after E0 and release after E1.
- cnt never wraps. It is cleared on every state entry and never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1.
- held is 1 in the cycle after entering PRESSED through the cycle of the release pulse's causing edge, i.e. it falls together with release asserting.
- Latency from btn_state change to event: exactly one clk.

Test Plan:
Bench uses LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4, reset released before E0 with btn_state=0.
- Short press: btn_state=1 sampled at E0..E2, 0 at E3 -> press and step after E0; click and release after E3; no long_press or rpt; held high after E0..E2 only.
- Long hold: btn_state=1 at E0..E19, 0 at E20 -> press after E0, long_press after E8, rpt and step after E12 and E16, release after E20; no click; step count = 3.
- Boundary: btn_state=1 at E0..E7, 0 at E8 -> release and click after E8; long_press never asserts. Repeat boundary: low exactly at E12 -> release after E12, no rpt.
- Reset mid-hold: in REPEAT, rst_n=0 at E14 -> all outputs 0 after E14, no release pulse. rst_n=1 with btn_state still 1 -> no press. btn_state=0 for one edge then 1 -> press one cycle after the high sample.
- Back-to-back: press, release, and re-press on consecutive sample edges (1,0,1) -> press, release, press on three consecutive cycles; cnt restarts at 0, so the second long_press lands 8 edges after the re-press edge.
